monitor_contador16: RTL and testbench
=====================================

# monitor_contador16

Downstream checking stage for the 16-bit cascaded counter made of four chained 4-bit stages. It observes the same `enb`/`modo`/`D` stimulus the counter receives, together with the counter's `Q` and final `RCO`. Each cycle it predicts the next count, compares the prediction against the observed `Q`, and counts mismatches and wrap events. Its registered status outputs feed the bench or a higher-level self-check.

## Interface
Parameters:
- `WIDTH`, default 16: counter width being monitored.
- `CNT_W`, default 8: width of the error and wrap counters; both saturate.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `enb` in 1: counter enable, the same net that drives the counter.
- `modo` in 2: counter mode. 00 = +1, 01 = −1, 10 = +3, 11 = load `D`.
- `D` in WIDTH: counter load value.
- `Q` in WIDTH: observed counter output.
- `RCO` in 1: ripple carry out of the top counter stage.
- `clr_err` in 1: clears error status and counters.
- `locked` out 1: high while in TRACK.
- `err` out 1: one-cycle pulse on a mismatch.
- `err_sticky` out 1: set by any mismatch; held until `clr_err` or reset.
- `err_count` out CNT_W: number of mismatches, saturating.
- `wrap_count` out CNT_W: number of `RCO` cycles seen in TRACK, saturating.
- `last_bad` out WIDTH: observed `Q` of the most recent mismatch.

## Operation
State machine: IDLE → SYNC → TRACK.
- IDLE: entered on reset. Moves to SYNC on the first edge with `enb`=1.
- SYNC: lasts one cycle. Captures `Q`, `enb`, `modo` and `D` into the reference registers `q_r`, `enb_r`, `modo_r`, `d_r`, then moves to TRACK. No check is made.
- TRACK: on every edge, compute `pred` from the previously captured values:
  - `enb_r`=0: `pred` = `q_r`.
  - `modo_r`=00: `pred` = `q_r`+1.
  - `modo_r`=01: `pred` = `q_r`−1.
  - `modo_r`=10: `pred` = `q_r`+3.
  - `modo_r`=11: `pred` = `d_r`.
- Arithmetic is modulo 2^WIDTH. 0xFFFF+1 = 0x0000, 0x0000−1 = 0xFFFF, 0xFFFE+3 = 0x0001.
- TRACK compares `Q` against `pred`. On a mismatch it pulses `err`, sets `err_sticky`, increments `err_count` and loads `last_bad` with `Q`.
- After every compare, match or mismatch, the reference registers reload from the current inputs. A mismatch therefore resynchronises the prediction and does not cascade.
- `wrap_count` increments on each TRACK edge where `RCO`=1. It is an event count only; `RCO` correctness is not checked.
- TRACK stays in TRACK; only `reset` returns the block to IDLE. `enb`=0 in TRACK checks that `Q` holds.
- `clr_err`, sampled at an edge, zeroes `err_sticky`, `err_count`, `wrap_count` and `last_bad`.
  - If a mismatch occurs at the same edge, the mismatch is applied after the clear: `err_count`=1, `err_sticky`=1, `last_bad`=`Q`.
  - If `RCO`=1 at the same edge, `wrap_count`=1 after the clear.
- Saturation: at 2^CNT_W−1 a counter holds its value. `err` and `last_bad` keep updating.

## Timing
- Reset values, on the edge with `reset`=1:
  - State IDLE; `locked`=0, `err`=0, `err_sticky`=0.
  - `err_count`=0, `wrap_count`=0, `last_bad`=0.
  - `q_r`, `d_r`, `modo_r`, `enb_r` = 0.
- `reset` overrides every other input, including mid-TRACK and together with `clr_err`.
- `locked` rises in the cycle after the SYNC edge, i.e. two edges after the first enabled edge seen in IDLE.
- Check latency: `Q` sampled at edge n is checked against the inputs sampled at edge n−1. `err` is high during the cycle following edge n.
- All outputs are registered; there is no combinational path from input to output.
- The first TRACK compare happens at the edge after SYNC.

## Test plan
- Reset, then `enb`=1, `modo`=00, correct counter from `Q`=0x0000 for 20 cycles:
  - `locked` rises after 2 edges.
  - `err` never pulses; `err_count`=0.
- Up-count across the boundary, `Q` 0xFFFE → 0xFFFF → 0x0000 with `RCO`=1 for one cycle:
  - No error; `wrap_count`=1.
- Down mode from 0x0001 to 0xFFFF, and +3 mode from 0xFFFE to 0x0001:
  - No error in either case.
- Fault injection: force `Q`=0x1234 where `pred`=0x0010, then continue counting correctly from 0x1235:
  - Exactly one `err` pulse; `err_count`=1, `err_sticky`=1, `last_bad`=0x1234.
- Load mode `modo`=11, `D`=0xA5A5, followed by a held cycle with `enb`=0:
  - `Q`=0xA5A5 is accepted for both cycles.
  - Injecting 0xA5A6 during the hold cycle raises `err`.
- Reset and clear precedence:
  - `clr_err` asserted on the same edge as a mismatch: `err_count`=1, not 0.
  - `reset` asserted mid-TRACK with `err_count`=5: all outputs return to 0 on that edge and the state returns to IDLE.
  - Saturation: 300 forced mismatches give `err_count`=255.

Source files
------------

// File: rtl/monitor_contador16_if.sv
// Stimulus/observation bundle between a cascaded counter and its checking monitor.
interface monitor_contador16_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
);
    logic             enb;
    logic [1:0]       modo;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             RCO;
    logic             clr_err;
    logic             locked;
    logic             err;
    logic             err_sticky;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] wrap_count;
    logic [WIDTH-1:0] last_bad;

    // Stimulus/observation side: drives counter nets, reads monitor status
    modport master (
        output enb, modo, D, Q, RCO, clr_err,
        input  locked, err, err_sticky, err_count, wrap_count, last_bad
    );

    // Monitor side
    modport slave (
        input  enb, modo, D, Q, RCO, clr_err,
        output locked, err, err_sticky, err_count, wrap_count, last_bad
    );
endinterface

// File: rtl/monitor_contador16.sv
// Checking stage for the 16-bit cascaded counter: predicts each next count,
// compares against the observed Q, and tallies mismatches and wrap events.
module monitor_contador16 #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    monitor_contador16_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SYNC  = 2'd1;
    localparam logic [1:0] TRACK = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] q_r, d_r;
    logic [1:0]       modo_r;
    logic             enb_r;

    logic             locked_q, err_q, sticky_q;
    logic [CNT_W-1:0] err_cnt_q, wrap_cnt_q;
    logic [WIDTH-1:0] last_bad_q;

    logic [WIDTH-1:0] pred_c;
    logic             mismatch_c;
    logic             wrap_c;
    logic [CNT_W-1:0] err_base_c, wrap_base_c;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.enb) state_d = SYNC;
            SYNC:    state_d = TRACK;
            TRACK:   state_d = TRACK;
            default: state_d = IDLE;
        endcase
    end

    // Prediction from the reference captured at the previous edge
    always_comb begin
        pred_c = q_r;
        if (enb_r) begin
            case (modo_r)
                2'b00:   pred_c = q_r + WIDTH'(1);
                2'b01:   pred_c = q_r - WIDTH'(1);
                2'b10:   pred_c = q_r + WIDTH'(3);
                default: pred_c = d_r;
            endcase
        end
    end

    // Compare/wrap events; a clear at the same edge is applied before the event
    always_comb begin
        mismatch_c  = (state_q == TRACK) && (bus.Q != pred_c);
        wrap_c      = (state_q == TRACK) && bus.RCO;
        err_base_c  = bus.clr_err ? '0 : err_cnt_q;
        wrap_base_c = bus.clr_err ? '0 : wrap_cnt_q;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Reference registers reload on the SYNC edge and after every TRACK compare
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r    <= '0;
            d_r    <= '0;
            modo_r <= '0;
            enb_r  <= 1'b0;
        end else if (state_q == SYNC || state_q == TRACK) begin
            q_r    <= bus.Q;
            d_r    <= bus.D;
            modo_r <= bus.modo;
            enb_r  <= bus.enb;
        end
    end

    // Status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            sticky_q   <= 1'b0;
            err_cnt_q  <= '0;
            wrap_cnt_q <= '0;
            last_bad_q <= '0;
        end else begin
            locked_q   <= (state_d == TRACK);
            err_q      <= mismatch_c;
            sticky_q   <= mismatch_c | (sticky_q & ~bus.clr_err);
            err_cnt_q  <= (mismatch_c && err_base_c != CNT_MAX) ? err_base_c + CNT_W'(1) : err_base_c;
            wrap_cnt_q <= (wrap_c && wrap_base_c != CNT_MAX) ? wrap_base_c + CNT_W'(1) : wrap_base_c;
            if (mismatch_c)       last_bad_q <= bus.Q;
            else if (bus.clr_err) last_bad_q <= '0;
        end
    end

    assign bus.locked     = locked_q;
    assign bus.err        = err_q;
    assign bus.err_sticky = sticky_q;
    assign bus.err_count  = err_cnt_q;
    assign bus.wrap_count = wrap_cnt_q;
    assign bus.last_bad   = last_bad_q;
endmodule

// File: tb/tb_monitor_contador16.sv
// Directed-vector bench for monitor_contador16.
module tb_monitor_contador16;
    logic clk = 1'b0;
    logic reset;

    monitor_contador16_if #(.WIDTH(16), .CNT_W(8)) bus ();

    monitor_contador16 #(.WIDTH(16), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic        rst;
        logic        enb;
        logic [1:0]  modo;
        logic [15:0] d;
        logic [15:0] q;
        logic        rco;
        logic        clr;
        logic        x_locked;
        logic        x_err;
        logic        x_sticky;
        logic [7:0]  x_errc;
        logic [7:0]  x_wrapc;
        logic [15:0] x_last;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [1:0] m,
                         input logic [15:0] d, input logic [15:0] q,
                         input logic rco, input logic clr);
        reset       = r;
        bus.enb     = e;
        bus.modo    = m;
        bus.D       = d;
        bus.Q       = q;
        bus.RCO     = rco;
        bus.clr_err = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic addv(input logic r, input logic e, input logic [1:0] m,
                        input logic [15:0] d, input logic [15:0] q,
                        input logic rco, input logic clr,
                        input logic xl, input logic xe, input logic xs,
                        input logic [7:0] xc, input logic [7:0] xw, input logic [15:0] xb);
        vec_t v;
        v.rst = r; v.enb = e; v.modo = m; v.d = d; v.q = q; v.rco = rco; v.clr = clr;
        v.x_locked = xl; v.x_err = xe; v.x_sticky = xs;
        v.x_errc = xc; v.x_wrapc = xw; v.x_last = xb;
        vt.push_back(v);
    endtask

    initial begin
        logic [15:0] cnt;

        drive(1'b1, 1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0);

        // Table: rst enb modo D Q RCO clr | locked err sticky errc wrapc last_bad
        addv(1,0,2'b00,16'h0000,16'h0000,0,0, 0,0,0,8'd0,8'd0,16'h0000);
        addv(0,1,2'b00,16'h0000,16'hFFFD,0,0, 0,0,0,8'd0,8'd0,16'h0000); // IDLE->SYNC
        addv(0,1,2'b00,16'h0000,16'hFFFE,0,0, 1,0,0,8'd0,8'd0,16'h0000); // SYNC capture
        addv(0,1,2'b00,16'h0000,16'hFFFF,0,0, 1,0,0,8'd0,8'd0,16'h0000);
        addv(0,1,2'b00,16'h0000,16'h0000,1,0, 1,0,0,8'd0,8'd1,16'h0000); // wrap
        addv(0,1,2'b01,16'h0000,16'h0001,0,0, 1,0,0,8'd0,8'd1,16'h0000);
        addv(0,1,2'b01,16'h0000,16'h0000,0,0, 1,0,0,8'd0,8'd1,16'h0000); // down
        addv(0,1,2'b01,16'h0000,16'hFFFF,0,0, 1,0,0,8'd0,8'd1,16'h0000); // 0000-1
        addv(0,1,2'b10,16'h0000,16'hFFFE,0,0, 1,0,0,8'd0,8'd1,16'h0000);
        addv(0,1,2'b10,16'h0000,16'h0001,0,0, 1,0,0,8'd0,8'd1,16'h0000); // FFFE+3
        addv(0,1,2'b11,16'h000F,16'h0004,0,0, 1,0,0,8'd0,8'd1,16'h0000);
        addv(0,1,2'b00,16'h0000,16'h000F,0,0, 1,0,0,8'd0,8'd1,16'h0000); // load 000F
        addv(0,1,2'b00,16'h0000,16'h1234,0,0, 1,1,1,8'd1,8'd1,16'h1234); // fault
        addv(0,1,2'b00,16'h0000,16'h1235,0,0, 1,0,1,8'd1,8'd1,16'h1234); // resync
        addv(0,1,2'b00,16'h0000,16'h1236,0,0, 1,0,1,8'd1,8'd1,16'h1234);
        addv(0,1,2'b11,16'hA5A5,16'h1237,0,0, 1,0,1,8'd1,8'd1,16'h1234);
        addv(0,0,2'b11,16'hA5A5,16'hA5A5,0,0, 1,0,1,8'd1,8'd1,16'h1234); // loaded
        addv(0,0,2'b11,16'hA5A5,16'hA5A5,0,0, 1,0,1,8'd1,8'd1,16'h1234); // held
        addv(0,0,2'b11,16'hA5A5,16'hA5A6,0,0, 1,1,1,8'd2,8'd1,16'hA5A6); // bad hold
        addv(0,1,2'b00,16'h0000,16'hA5A6,0,1, 1,0,0,8'd0,8'd0,16'h0000); // clear
        addv(0,1,2'b00,16'h0000,16'h0100,1,1, 1,1,1,8'd1,8'd1,16'h0100); // clr+err+rco
        addv(0,1,2'b00,16'h0000,16'h0101,0,0, 1,0,1,8'd1,8'd1,16'h0100);
        addv(1,1,2'b00,16'h0000,16'h5555,1,1, 0,0,0,8'd0,8'd0,16'h0000); // reset wins
        addv(0,0,2'b00,16'h0000,16'h0000,0,0, 0,0,0,8'd0,8'd0,16'h0000); // stays IDLE

        // Sequence: clean up-count from 0 for 20 cycles
        drive(1'b1, 1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
        step();
        chk("rst_locked", 32'(bus.locked), 32'd0);
        chk("rst_errc", 32'(bus.err_count), 32'd0);
        cnt = 16'h0000;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 2'b00, 16'h0, cnt, 1'b0, 1'b0);
            step();
            chk($sformatf("up_locked[%0d]", i), 32'(bus.locked), (i >= 1) ? 32'd1 : 32'd0);
            chk($sformatf("up_err[%0d]", i), 32'(bus.err), 32'd0);
            cnt = cnt + 16'd1;
        end
        chk("up_errc", 32'(bus.err_count), 32'd0);

        // Sequence: five mismatches, then reset mid-TRACK
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 2'b00, 16'h0, 16'h8000, 1'b0, 1'b0);
            step();
        end
        chk("five_errc", 32'(bus.err_count), 32'd5);
        chk("five_err", 32'(bus.err), 32'd1);
        drive(1'b1, 1'b1, 2'b00, 16'h0, 16'h8000, 1'b0, 1'b0);
        step();
        chk("midrst_locked", 32'(bus.locked), 32'd0);
        chk("midrst_err", 32'(bus.err), 32'd0);
        chk("midrst_sticky", 32'(bus.err_sticky), 32'd0);
        chk("midrst_errc", 32'(bus.err_count), 32'd0);
        chk("midrst_last", 32'(bus.last_bad), 32'd0);
        // Back in IDLE: needs an enabled edge plus the SYNC edge to lock
        drive(1'b0, 1'b0, 2'b00, 16'h0, 16'h1111, 1'b0, 1'b0);
        step();
        chk("idle_hold_locked", 32'(bus.locked), 32'd0);
        drive(1'b0, 1'b1, 2'b00, 16'h0, 16'h2222, 1'b0, 1'b0);
        step();
        chk("idle_sync_locked", 32'(bus.locked), 32'd0);
        chk("idle_sync_err", 32'(bus.err), 32'd0);
        drive(1'b0, 1'b1, 2'b00, 16'h0, 16'h8000, 1'b0, 1'b0);
        step();
        chk("relock_locked", 32'(bus.locked), 32'd1);
        chk("relock_err", 32'(bus.err), 32'd0);

        // Sequence: 300 forced mismatches saturate the error counter
        for (int i = 0; i < 299; i++) begin
            drive(1'b0, 1'b1, 2'b00, 16'h0, 16'h8000, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 1'b1, 2'b00, 16'h0, 16'h7777, 1'b0, 1'b0);
        step();
        chk("sat_errc", 32'(bus.err_count), 32'd255);
        chk("sat_err", 32'(bus.err), 32'd1);
        chk("sat_last", 32'(bus.last_bad), 32'h7777);

        // Table-driven vectors
        foreach (vt[k]) begin
            drive(vt[k].rst, vt[k].enb, vt[k].modo, vt[k].d, vt[k].q, vt[k].rco, vt[k].clr);
            step();
            chk($sformatf("v%0d_locked", k), 32'(bus.locked), 32'(vt[k].x_locked));
            chk($sformatf("v%0d_err", k), 32'(bus.err), 32'(vt[k].x_err));
            chk($sformatf("v%0d_sticky", k), 32'(bus.err_sticky), 32'(vt[k].x_sticky));
            chk($sformatf("v%0d_errc", k), 32'(bus.err_count), 32'(vt[k].x_errc));
            chk($sformatf("v%0d_wrapc", k), 32'(bus.wrap_count), 32'(vt[k].x_wrapc));
            chk($sformatf("v%0d_last", k), 32'(bus.last_bad), 32'(vt[k].x_last));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
